branch_pc_sequencer: RTL and testbench
======================================

// Module: branch_pc_sequencer
// PURPOSE
//  Owns the program counter and sequences conditional-branch resolution in front of the fetch stage.
//  Accepts one branch request at a time from decode over a valid/ready handshake.
//  Evaluates the comparison in a registered EVAL cycle and redirects the PC when the branch is taken.
//  Then drives a counted pipeline flush. Otherwise the PC advances sequentially by 4 on every unstalled cycle.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value loaded on reset
//  FLUSH_CYCLES 2              cycles flush held high after a taken redirect (>=1)
//  CNT_W        16             width of the taken-branch statistics counter
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  stall        in   1      1 = hold PC (fetch back-pressure)
//  br_valid     in   1      branch request valid
//  br_ready     out  1      sequencer can accept a request
//  br_opcode    in   5      branch kind (encoding below)
//  br_rs1       in   32     comparison operand 1
//  br_rs2       in   32     comparison operand 2
//  br_pc        in   32     PC of the branch instruction
//  br_imm       in   32     sign-extended byte offset
//  pc           out  32     current fetch PC
//  pc_valid     out  1      pc is a valid fetch address (0 during EVAL/FLUSH)
//  flush        out  1      kill younger in-flight instructions
//  taken        out  1      1-cycle pulse: redirect committed
//  misalign_err out  1      1-cycle pulse: taken target not 4-byte aligned
//  taken_count  out  CNT_W  number of committed taken branches, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, pc_valid=0, br_ready=0, flush=0, taken=0,
//   misalign_err=0, taken_count=0. The first clock edge after release sets pc_valid=1 and br_ready=1 without incrementing pc.
//  Opcodes: 00000 BEQ ==; 00001 BNE !=; 00100 BLT signed <; 00101 BGE signed >=;
//   00110 BLTU unsigned <; 00111 BGEU unsigned >=; all others (incl. 11111) = not-taken.
//  States: IDLE, EVAL, FLUSH.
//  IDLE: br_ready=1. If stall=0, pc<=pc+4 (mod 2^32, wraps silently). If br_valid&br_ready, latch
//   opcode/rs1/rs2/target, go EVAL. The handshake wins over the increment: pc is not incremented that cycle.
//  target = br_pc + br_imm, 32-bit wrap-around, computed at acceptance.
//  EVAL (1 cycle, ignores stall): br_ready=0, pc_valid=0. Compare latched operands.
//   not-taken -> pc<=latched br_pc+4, go IDLE.
//   taken & target[1:0]==0 -> pc<=target, taken=1 next cycle, flush=1, taken_count+1 (saturates at all-ones), go FLUSH.
//   taken & target[1:0]!=0 -> misalign_err=1 next cycle, pc<=br_pc+4, no flush, no count, go IDLE.
//  FLUSH: flush=1, br_ready=0, pc_valid=0. Down-counter loaded with FLUSH_CYCLES-1.
//   Return to IDLE when the counter reaches 0, so flush is high for exactly FLUSH_CYCLES cycles. stall is ignored.
//  Latency: request accept -> redirected pc visible = 2 edges; not-taken -> pc visible = 2 edges.
//  br_valid while br_ready=0 is ignored; the requester holds its request until it is accepted.
//  Reset mid-EVAL/FLUSH: immediate return to reset values; the pending branch is discarded.
//  taken and misalign_err are never high in the same cycle.
// TESTING
//  Reset: rst_n=0 then released -> pc=0, pc_valid=1 after 1 edge; 3 unstalled edges -> pc=0xC.
//  BEQ rs1=rs2=5, br_pc=0x100, imm=0x40 -> pc=0x140, taken pulse, flush high for 2 cycles, taken_count=1.
//  BLT rs1=0xFFFFFFFF, rs2=1 -> taken (signed). BLTU with same operands -> not taken, pc=br_pc+4.
//  Taken BNE with imm=0x2 -> misalign_err pulse, pc=br_pc+4, flush stays 0, count unchanged.
//  stall=1 in IDLE holds pc; br_valid during FLUSH -> br_ready=0, request accepted only after return to IDLE.
//  rst_n pulsed low during FLUSH -> flush=0, pc=RESET_PC asynchronously; br_pc=0xFFFFFFFC, imm=4 -> pc wraps to 0.

Source files
------------

// File: rtl/branch_pc_sequencer.sv
// Program-counter owner and conditional-branch sequencer ahead of fetch.
// Accepts one branch at a time, resolves it in EVAL, redirects and flushes on taken.
module branch_pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [4:0]       br_opcode,
    input  logic [31:0]      br_rs1,
    input  logic [31:0]      br_rs2,
    input  logic [31:0]      br_pc,
    input  logic [31:0]      br_imm,
    output logic [31:0]      pc,
    output logic             pc_valid,
    output logic             flush,
    output logic             taken,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_count
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      lat_op;
    logic [31:0]     lat_rs1;
    logic [31:0]     lat_rs2;
    logic [31:0]     lat_target;
    logic [31:0]     lat_seq_pc;
    logic [FC_W-1:0] flush_cnt;
    logic            cond_taken;

    always_comb begin
        cond_taken = 1'b0;
        unique case (lat_op)
            5'b00000: cond_taken = (lat_rs1 == lat_rs2);
            5'b00001: cond_taken = (lat_rs1 != lat_rs2);
            5'b00100: cond_taken = ($signed(lat_rs1) <  $signed(lat_rs2));
            5'b00101: cond_taken = ($signed(lat_rs1) >= $signed(lat_rs2));
            5'b00110: cond_taken = (lat_rs1 <  lat_rs2);
            5'b00111: cond_taken = (lat_rs1 >= lat_rs2);
            default:  cond_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            pc_valid     <= 1'b0;
            br_ready     <= 1'b0;
            flush        <= 1'b0;
            taken        <= 1'b0;
            misalign_err <= 1'b0;
            taken_count  <= '0;
            lat_op       <= '0;
            lat_rs1      <= '0;
            lat_rs2      <= '0;
            lat_target   <= '0;
            lat_seq_pc   <= '0;
            flush_cnt    <= '0;
        end else begin
            taken        <= 1'b0;
            misalign_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    // br_ready low here only on the first cycle out of reset: arm without advancing pc
                    if (!br_ready) begin
                        br_ready <= 1'b1;
                        pc_valid <= 1'b1;
                    end else if (br_valid) begin
                        lat_op     <= br_opcode;
                        lat_rs1    <= br_rs1;
                        lat_rs2    <= br_rs2;
                        lat_target <= br_pc + br_imm;
                        lat_seq_pc <= br_pc + 32'd4;
                        br_ready   <= 1'b0;
                        pc_valid   <= 1'b0;
                        state      <= EVAL;
                    end else if (!stall) begin
                        pc <= pc + 32'd4;
                    end
                end
                EVAL: begin
                    if (cond_taken && (lat_target[1:0] == 2'b00)) begin
                        pc        <= lat_target;
                        taken     <= 1'b1;
                        flush     <= 1'b1;
                        flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
                        if (taken_count != '1)
                            taken_count <= taken_count + CNT_W'(1);
                        state     <= FLUSH;
                    end else begin
                        pc           <= lat_seq_pc;
                        misalign_err <= cond_taken;
                        br_ready     <= 1'b1;
                        pc_valid     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        flush    <= 1'b0;
                        br_ready <= 1'b1;
                        pc_valid <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Directed self-checking bench for branch_pc_sequencer.
module tb_branch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_valid;
    logic        br_ready;
    logic [4:0]  br_opcode;
    logic [31:0] br_rs1, br_rs2, br_pc, br_imm;
    logic [31:0] pc;
    logic        pc_valid, flush, taken, misalign_err;
    logic [15:0] taken_count;

    int n_cmp = 0;
    int n_err = 0;

    branch_pc_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .FLUSH_CYCLES(2),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_opcode   (br_opcode),
        .br_rs1      (br_rs1),
        .br_rs2      (br_rs2),
        .br_pc       (br_pc),
        .br_imm      (br_imm),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .flush       (flush),
        .taken       (taken),
        .misalign_err(misalign_err),
        .taken_count (taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] bpc, input logic [31:0] imm);
        br_opcode = op; br_rs1 = a; br_rs2 = b; br_pc = bpc; br_imm = imm;
        br_valid  = 1'b1;
        step();
        br_valid  = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int unsigned n = 0;
        while (br_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, 32'(br_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; br_valid = 1'b0;
        br_opcode = '0; br_rs1 = '0; br_rs2 = '0; br_pc = '0; br_imm = '0;

        // Reset values
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_valid", 32'(pc_valid), 32'd0);
        chk("rst_br_ready", 32'(br_ready), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_count", 32'(taken_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arm_pc", pc, 32'h0);
        chk("arm_pc_valid", 32'(pc_valid), 32'd1);
        chk("arm_br_ready", 32'(br_ready), 32'd1);
        step(); step(); step();
        chk("seq_pc", pc, 32'hC);

        // Stall holds pc
        stall = 1'b1;
        step(); step();
        chk("stall_pc", pc, 32'hC);
        stall = 1'b0;

        // BEQ taken
        issue(5'b00000, 32'd5, 32'd5, 32'h100, 32'h40);
        chk("beq_acc_pc", pc, 32'hC);
        chk("beq_acc_ready", 32'(br_ready), 32'd0);
        chk("beq_eval_pc_valid", 32'(pc_valid), 32'd0);
        step();
        chk("beq_pc", pc, 32'h140);
        chk("beq_taken", 32'(taken), 32'd1);
        chk("beq_flush1", 32'(flush), 32'd1);
        chk("beq_count", 32'(taken_count), 32'd1);
        step();
        chk("beq_taken_pulse", 32'(taken), 32'd0);
        chk("beq_flush2", 32'(flush), 32'd1);
        step();
        chk("beq_flush_end", 32'(flush), 32'd0);
        chk("beq_ready_back", 32'(br_ready), 32'd1);
        chk("beq_pc_hold", pc, 32'h140);
        step();
        chk("beq_pc_inc", pc, 32'h144);

        // BLT signed taken
        issue(5'b00100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10);
        step();
        chk("blt_pc", pc, 32'h210);
        chk("blt_taken", 32'(taken), 32'd1);
        chk("blt_count", 32'(taken_count), 32'd2);
        wait_ready("blt_ready");

        // BLTU same operands not taken
        issue(5'b00110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10);
        step();
        chk("bltu_pc", pc, 32'h304);
        chk("bltu_taken", 32'(taken), 32'd0);
        chk("bltu_flush", 32'(flush), 32'd0);
        chk("bltu_ready", 32'(br_ready), 32'd1);

        // BNE taken, misaligned
        issue(5'b00001, 32'd1, 32'd2, 32'h400, 32'h2);
        step();
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_pc", pc, 32'h404);
        chk("mis_taken", 32'(taken), 32'd0);
        chk("mis_flush", 32'(flush), 32'd0);
        chk("mis_count", 32'(taken_count), 32'd2);
        step();
        chk("mis_pulse", 32'(misalign_err), 32'd0);

        // Undefined opcode never taken
        issue(5'b11111, 32'd7, 32'd7, 32'h480, 32'h40);
        step();
        chk("undef_pc", pc, 32'h484);
        chk("undef_taken", 32'(taken), 32'd0);

        // Request presented during FLUSH waits for IDLE
        issue(5'b00101, 32'd3, 32'd3, 32'h500, 32'h20);
        step();
        chk("bge_pc", pc, 32'h520);
        br_opcode = 5'b00111; br_rs1 = 32'd1; br_rs2 = 32'd0; br_pc = 32'h600; br_imm = 32'h8;
        br_valid = 1'b1;
        chk("fl_ready0", 32'(br_ready), 32'd0);
        step();
        chk("fl_ready1", 32'(br_ready), 32'd0);
        chk("fl_pc1", pc, 32'h520);
        step();
        chk("fl_ready_back", 32'(br_ready), 32'd1);
        chk("fl_pc2", pc, 32'h520);
        step();
        br_valid = 1'b0;
        chk("fl_accept_ready", 32'(br_ready), 32'd0);
        chk("fl_accept_pc", pc, 32'h520);
        step();
        chk("bgeu_pc", pc, 32'h608);
        chk("bgeu_taken", 32'(taken), 32'd1);
        chk("bgeu_count", 32'(taken_count), 32'd4);

        // Async reset during FLUSH
        chk("pre_rst_flush", 32'(flush), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_count", 32'(taken_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rearm_ready", 32'(br_ready), 32'd1);

        // Target wraps to 0
        issue(5'b00000, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h4);
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_taken", 32'(taken), 32'd1);
        chk("wrap_count", 32'(taken_count), 32'd1);
        wait_ready("wrap_ready");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
